// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART encodings and framing constants.
//               The word-packing receiver imports these constants too.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Framing constants
  localparam int OVERSAMPLE     = 16;
  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  // Counter widths: tick wraps 15->0, bit_idx 0..7, byte_idx 0..3
  localparam int TICK_W = 4;
  localparam int BIT_W  = 3;
  localparam int BYTE_W = 2;

  // Frame state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Select byte lane idx of a 32-bit word
  function automatic logic [7:0] byte_lane(input logic [WORD_W-1:0] word,
                                           input logic [BYTE_W-1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer, 16 clken ticks per bit. A load pulse
//               starts a frame immediately (independent of clken); a load on
//               the final stop tick chains the next frame with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_end
);

  uart_state_e       state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [BIT_W-1:0]  bit_idx, bit_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              tx_nxt;
  logic              tick_last;

  assign tick_last = (tick == TICK_W'(OVERSAMPLE - 1));

  // Final tick of the stop bit; does not depend on load, so no comb loop
  assign frame_end = clken && (state == STOP) && tick_last;

  // Frame state, counters and registered line driver
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  // Next-state and next-line logic; load has priority over tick handling
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = tx;
    if (load) begin
      state_nxt = START;
      tick_nxt  = '0;
      bit_nxt   = '0;
      shift_nxt = data;
      tx_nxt    = 1'b0;
    end else if (clken) begin
      tick_nxt = tick + 1'b1;
      unique case (state)
        IDLE: begin
          tick_nxt = '0;
          tx_nxt   = 1'b1;
        end
        START: begin
          if (tick_last) begin
            bit_nxt   = '0;
            tx_nxt    = shift[0];
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (tick_last) begin
            if (bit_idx != BIT_W'(BITS_PER_BYTE - 1)) begin
              bit_nxt   = bit_idx + 1'b1;
              shift_nxt = shift >> 1;
              tx_nxt    = shift[1];
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = STOP;
            end
          end
        end
        STOP: begin
          if (tick_last) begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_word.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_word
// Description : Word UART transmitter. Sends a DATA_WIDTH-bit word as four
//               back-to-back 8N1 frames, LS byte first; lanes above
//               DATA_WIDTH are sent as 0x00.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_word
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  logic [WORD_W-1:0] buffer;
  logic [WORD_W-1:0] data_ext;
  logic [BYTE_W-1:0] byte_idx;
  logic              accept;
  logic              frame_end;
  logic              last_byte;
  logic              byte_load;
  logic [7:0]        byte_data;

  assign accept    = wr_en && !busy;
  assign last_byte = (byte_idx == BYTE_W'(BYTES_PER_WORD - 1));

  // Zero-extend the input word into the 32-bit lane space
  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = data_in;
  end

  // Chain the next byte on the final stop tick, or start byte 0 on accept
  always_comb begin
    byte_load = accept || (busy && frame_end && !last_byte);
    byte_data = accept ? data_ext[7:0] : byte_lane(buffer, byte_idx + 1'b1);
  end

  // Word buffer, byte index and busy/done handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer   <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        buffer   <= data_ext;
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (busy && frame_end) begin
        if (last_byte) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  uart_tx_byte u_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .load      (byte_load),
    .data      (byte_data),
    .tx        (tx),
    .frame_end (frame_end)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_word.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_word
// Description : Directed self-checking bench for uart_tx_word (32- and 16-bit
//               instances sharing clock, reset and clken).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_word;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b0;
  logic [31:0] data32 = '0;
  logic        wr32 = 1'b0;
  logic        tx32, busy32, done32;
  logic [15:0] data16 = '0;
  logic        wr16 = 1'b0;
  logic        tx16, busy16, done16;

  int checks = 0;
  int errors = 0;
  int div = 1;
  int phase = 0;

  always #5 clk = ~clk;

  uart_tx_word #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .clken(clken), .data_in(data32),
    .wr_en(wr32), .tx(tx32), .busy(busy32), .done(done32)
  );

  uart_tx_word #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .clken(clken), .data_in(data16),
    .wr_en(wr16), .tx(tx16), .busy(busy16), .done(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then set clken for the coming rising edge
  task automatic cyc();
    @(negedge clk);
    phase = (phase + 1) % div;
    clken = (phase == 0);
  endtask

  // Expected line level for frame bit j of a word (10 bits per byte)
  function automatic logic exp_bit(input logic [31:0] word, input int j);
    logic [7:0] b;
    int p;
    b = word[(j / 10) * 8 +: 8];
    p = j % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p - 1];
  endfunction

  // Send one word and check every bit mid-period plus busy/done timing.
  // ignore_at >= 0 issues a 0xDEADBEEF write at that cycle while busy.
  task automatic run_word(input bit sel16, input logic [31:0] word,
                          input int d, input int ignore_at, input string tag);
    int bitlen;
    int total;
    logic t, b, dn;
    bitlen = 16 * d;
    total  = 40 * bitlen;
    div    = d;
    phase  = d - 1;
    cyc();
    if (sel16) begin data16 = word[15:0]; wr16 = 1'b1; end
    else       begin data32 = word;       wr32 = 1'b1; end
    for (int k = 0; k <= total + 1; k++) begin
      cyc();
      if (k == 0) begin wr16 = 1'b0; wr32 = 1'b0; end
      if (k == ignore_at) begin data32 = 32'hDEADBEEF; wr32 = 1'b1; end
      if (k == ignore_at + 1) wr32 = 1'b0;
      t  = sel16 ? tx16   : tx32;
      b  = sel16 ? busy16 : busy32;
      dn = sel16 ? done16 : done32;
      if (k == 0) begin
        chk({tag, "_tx_low_at_accept"}, t, 1'b0);
        chk({tag, "_busy_at_accept"}, b, 1'b1);
      end
      if (k < total && (k % bitlen) == bitlen / 2)
        chk($sformatf("%s_bit%0d", tag, k / bitlen), t, exp_bit(word, k / bitlen));
      if (k == total - 1) begin
        chk({tag, "_busy_before_end"}, b, 1'b1);
        chk({tag, "_done_early"}, dn, 1'b0);
      end
      if (k == total) begin
        chk({tag, "_done_pulse"}, dn, 1'b1);
        chk({tag, "_busy_fall"}, b, 1'b0);
        chk({tag, "_tx_idle_end"}, t, 1'b1);
      end
      if (k == total + 1) begin
        chk({tag, "_done_width"}, dn, 1'b0);
        chk({tag, "_still_idle"}, b, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset and idle
    div = 1; phase = 0;
    repeat (3) cyc();
    chk("rst_tx", tx32, 1'b1);
    chk("rst_busy", busy32, 1'b0);
    chk("rst_done", done32, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk("idle_line", {busy32, done32, tx32, busy16, done16, tx16}, 6'b001001);
    end

    // Basic word, clken every cycle: done at 640 clk
    run_word(1'b0, 32'h12345678, 1, -1, "w12345678");
    repeat (5) cyc();

    // clken every 3rd cycle: 48 clk per bit, 1920 clk per word
    run_word(1'b0, 32'hA5A5A5A5, 3, -1, "wA5_div3");
    repeat (5) cyc();

    // Write while busy is ignored; word in flight completes unchanged
    run_word(1'b0, 32'h11223344, 1, 300, "w_ignore");
    repeat (5) cyc();

    // 16-bit instance: upper lanes sent as 0x00
    run_word(1'b1, 32'h0000BEEF, 1, -1, "w16_beef");
    repeat (5) cyc();

    // Reset during DATA bit 3 of byte 1 (frame bit 14 -> clk 224..239)
    div = 1; phase = 0;
    cyc();
    data32 = 32'hFFFFFFFF; wr32 = 1'b1;
    for (int k = 0; k < 230; k++) begin
      cyc();
      if (k == 0) wr32 = 1'b0;
    end
    chk("pre_rst_busy", busy32, 1'b1);
    chk("pre_rst_tx_bit", tx32, 1'b1);
    data32 = 32'h00000000;
    wr32 = 1'b1; cyc(); wr32 = 1'b0;
    chk("pre_rst_ignore_busy", busy32, 1'b1);
    chk("pre_rst_tx_data", tx32, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx32, 1'b1);
    chk("async_rst_busy", busy32, 1'b0);
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    run_word(1'b0, 32'h0000FFFF, 1, -1, "w_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
